// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Hazard bubbles are inserted locally and tallied in a saturating counter.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic             Branch_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemWrite_o,
  output logic             MemRead_o,
  output logic             Branch_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             valid_o,
  output logic             noop_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [1:0]       r_aluop;
  logic             r_alusrc;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_memwrite;
  logic             r_memread;
  logic             r_branch;
  logic [XLEN-1:0]  r_rs1data;
  logic [XLEN-1:0]  r_rs2data;
  logic [XLEN-1:0]  r_imm;
  logic [9:0]       r_funct;
  logic [4:0]       r_rs1addr;
  logic [4:0]       r_rs2addr;
  logic [4:0]       r_rdaddr;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic w_hazard;
  logic w_bubble;
  logic w_cnt_max;

  assign w_hazard = r_memread & r_valid & (r_rdaddr != 5'd0) &
                    ((r_rdaddr == RS1addr_i) |
                     (r_rdaddr == RS2addr_i));
  assign w_bubble  = flush_i | w_hazard;
  assign w_cnt_max = &r_cnt;

  assign noop_o        = w_hazard;
  assign pc_write_o    = ~w_hazard & ~stall_i;
  assign if_id_write_o = ~w_hazard & ~stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_aluop    <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_branch   <= 1'b0;
      r_rs1data  <= '0;
      r_rs2data  <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1addr  <= '0;
      r_rs2addr  <= '0;
      r_rdaddr   <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else if (!stall_i) begin
      // Operands still move on a bubble; only effects are squashed
      r_rs1data <= RS1data_i;
      r_rs2data <= RS2data_i;
      r_imm     <= imm_i;
      r_funct   <= funct_i;
      r_rs1addr <= RS1addr_i;
      r_rs2addr <= RS2addr_i;
      if (w_bubble) begin
        r_aluop    <= '0;
        r_alusrc   <= 1'b0;
        r_regwrite <= 1'b0;
        r_memtoreg <= 1'b0;
        r_memwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_branch   <= 1'b0;
        r_rdaddr   <= '0;
        r_valid    <= 1'b0;
      end else begin
        r_aluop    <= ALUOp_i;
        r_alusrc   <= ALUSrc_i;
        r_regwrite <= RegWrite_i;
        r_memtoreg <= MemtoReg_i;
        r_memwrite <= MemWrite_i;
        r_memread  <= MemRead_i;
        r_branch   <= Branch_i;
        r_rdaddr   <= RDaddr_i;
        r_valid    <= 1'b1;
      end
      if (w_hazard && !w_cnt_max)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ALUOp_o      = r_aluop;
  assign ALUSrc_o     = r_alusrc;
  assign RegWrite_o   = r_regwrite;
  assign MemtoReg_o   = r_memtoreg;
  assign MemWrite_o   = r_memwrite;
  assign MemRead_o    = r_memread;
  assign Branch_o     = r_branch;
  assign RS1data_o    = r_rs1data;
  assign RS2data_o    = r_rs2data;
  assign imm_o        = r_imm;
  assign funct_o      = r_funct;
  assign RS1addr_o    = r_rs1addr;
  assign RS2addr_o    = r_rs2addr;
  assign RDaddr_o     = r_rdaddr;
  assign valid_o      = r_valid;
  assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [1:0]  aluop;
  logic        alusrc, regwrite, memtoreg;
  logic        memwrite, memread, branch;
  logic [31:0] rs1data, rs2data, imm;
  logic [9:0]  funct;
  logic [4:0]  rs1a, rs2a, rda;

  logic [1:0]  aluop_o;
  logic        alusrc_o, regwrite_o, memtoreg_o;
  logic        memwrite_o, memread_o, branch_o;
  logic [31:0] rs1data_o, rs2data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1a_o, rs2a_o, rda_o;
  logic        valid_o, noop_o, pcw_o, ifw_o;
  logic [15:0] cnt_o;

  logic [1:0]  s_aluop;
  logic        s_alusrc, s_regwrite, s_memtoreg;
  logic        s_memwrite, s_memread, s_branch;
  logic [31:0] s_rs1data, s_rs2data, s_imm;
  logic [9:0]  s_funct;
  logic [4:0]  s_rs1a, s_rs2a, s_rda;
  logic        s_valid, s_noop, s_pcw, s_ifw;
  logic [1:0]  s_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .stall_i(stall), .flush_i(flush),
    .ALUOp_i(aluop), .ALUSrc_i(alusrc),
    .RegWrite_i(regwrite), .MemtoReg_i(memtoreg),
    .MemWrite_i(memwrite), .MemRead_i(memread),
    .Branch_i(branch),
    .RS1data_i(rs1data), .RS2data_i(rs2data),
    .imm_i(imm), .funct_i(funct),
    .RS1addr_i(rs1a), .RS2addr_i(rs2a),
    .RDaddr_i(rda),
    .ALUOp_o(aluop_o), .ALUSrc_o(alusrc_o),
    .RegWrite_o(regwrite_o), .MemtoReg_o(memtoreg_o),
    .MemWrite_o(memwrite_o), .MemRead_o(memread_o),
    .Branch_o(branch_o),
    .RS1data_o(rs1data_o), .RS2data_o(rs2data_o),
    .imm_o(imm_o), .funct_o(funct_o),
    .RS1addr_o(rs1a_o), .RS2addr_o(rs2a_o),
    .RDaddr_o(rda_o), .valid_o(valid_o),
    .noop_o(noop_o), .pc_write_o(pcw_o),
    .if_id_write_o(ifw_o), .bubble_cnt_o(cnt_o)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_n),
    .stall_i(stall), .flush_i(flush),
    .ALUOp_i(aluop), .ALUSrc_i(alusrc),
    .RegWrite_i(regwrite), .MemtoReg_i(memtoreg),
    .MemWrite_i(memwrite), .MemRead_i(memread),
    .Branch_i(branch),
    .RS1data_i(rs1data), .RS2data_i(rs2data),
    .imm_i(imm), .funct_i(funct),
    .RS1addr_i(rs1a), .RS2addr_i(rs2a),
    .RDaddr_i(rda),
    .ALUOp_o(s_aluop), .ALUSrc_o(s_alusrc),
    .RegWrite_o(s_regwrite), .MemtoReg_o(s_memtoreg),
    .MemWrite_o(s_memwrite), .MemRead_o(s_memread),
    .Branch_o(s_branch),
    .RS1data_o(s_rs1data), .RS2data_o(s_rs2data),
    .imm_o(s_imm), .funct_o(s_funct),
    .RS1addr_o(s_rs1a), .RS2addr_o(s_rs2a),
    .RDaddr_o(s_rda), .valid_o(s_valid),
    .noop_o(s_noop), .pc_write_o(s_pcw),
    .if_id_write_o(s_ifw), .bubble_cnt_o(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    aluop = 2'd0; alusrc = 0; regwrite = 0;
    memtoreg = 0; memwrite = 0; memread = 0;
    branch = 0; rs1data = '0; rs2data = '0;
    imm = '0; funct = '0;
    rs1a = '0; rs2a = '0; rda = '0;
  endtask

  task automatic id_load(input logic [4:0] rd,
                         input logic [4:0] rs1);
    id_clear();
    memread = 1; memtoreg = 1; regwrite = 1;
    alusrc = 1; rda = rd; rs1a = rs1;
    imm = 32'h10;
  endtask

  task automatic id_add(input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2);
    id_clear();
    regwrite = 1; aluop = 2'd2;
    rda = rd; rs1a = rs1; rs2a = rs2;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0;
    aluop = 2'd3; alusrc = 1; regwrite = 1;
    memtoreg = 1; memwrite = 1; memread = 1;
    branch = 1;
    rs1data = 32'hA5A5_0001; rs2data = 32'h5A5A_0002;
    imm = 32'hDEAD_BEEF; funct = 10'h2A5;
    rs1a = 5'd1; rs2a = 5'd2; rda = 5'd3;
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_rs1data", rs1data_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_noop", noop_o, 0);
    rst_n = 1'b1;
    tick();
    chk("pre_valid", valid_o, 1);
    chk("pre_rs1data", rs1data_o, 32'hA5A5_0001);
    chk("pre_aluop", aluop_o, 2'd3);
    chk("pre_memread", memread_o, 1);
    // asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_rs1data", rs1data_o, 0);
    chk("arst_imm", imm_o, 0);
    chk("arst_funct", funct_o, 0);
    chk("arst_rd", rda_o, 0);
    chk("arst_memread", memread_o, 0);
    chk("arst_noop", noop_o, 0);
    chk("arst_pcw", pcw_o, 1);
    stall = 1;
    #1;
    chk("arst_pcw_stall", pcw_o, 0);
    stall = 0;
    rst_n = 1'b1;

    // normal capture: addi x5, x1, -4
    id_clear();
    alusrc = 1; regwrite = 1; aluop = 2'd0;
    rs1data = 32'h1234_5678; imm = 32'hFFFF_FFFC;
    rda = 5'd5; rs1a = 5'd1;
    tick();
    chk("cap_alusrc", alusrc_o, 1);
    chk("cap_regwrite", regwrite_o, 1);
    chk("cap_aluop", aluop_o, 0);
    chk("cap_rs1data", rs1data_o, 32'h1234_5678);
    chk("cap_imm", imm_o, 32'hFFFF_FFFC);
    chk("cap_rd", rda_o, 5);
    chk("cap_valid", valid_o, 1);
    chk("cap_memread", memread_o, 0);

    // load-use: lw x7 then add x8, x1, x7
    id_load(5'd7, 5'd2);
    tick();
    chk("lw_memread", memread_o, 1);
    chk("lw_rd", rda_o, 7);
    id_add(5'd8, 5'd1, 5'd7);
    #1;
    chk("lu_noop", noop_o, 1);
    chk("lu_pcw", pcw_o, 0);
    chk("lu_ifw", ifw_o, 0);
    tick();
    chk("bub_regwrite", regwrite_o, 0);
    chk("bub_rd", rda_o, 0);
    chk("bub_valid", valid_o, 0);
    chk("bub_cnt", cnt_o, 1);
    chk("bub_rs2a", rs2a_o, 7);
    chk("bub_noop", noop_o, 0);
    tick();
    chk("dep_valid", valid_o, 1);
    chk("dep_rd", rda_o, 8);
    chk("dep_regwrite", regwrite_o, 1);
    chk("dep_cnt", cnt_o, 1);

    // x0 destination and non-load producers
    id_load(5'd0, 5'd3);
    tick();
    id_add(5'd9, 5'd0, 5'd0);
    #1;
    chk("x0_noop", noop_o, 0);
    id_add(5'd7, 5'd1, 5'd2);
    tick();
    id_add(5'd9, 5'd7, 5'd1);
    #1;
    chk("nl_noop", noop_o, 0);
    chk("nl_pcw", pcw_o, 1);

    // stall wins over hazard
    id_load(5'd9, 5'd1);
    tick();
    id_add(5'd10, 5'd9, 5'd1);
    stall = 1;
    #1;
    chk("st_noop", noop_o, 1);
    chk("st_pcw", pcw_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_rd", rda_o, 9);
      chk("st_valid", valid_o, 1);
      chk("st_cnt", cnt_o, 1);
      chk("st_ifw", ifw_o, 0);
    end
    stall = 0;
    tick();
    chk("rel_valid", valid_o, 0);
    chk("rel_rd", rda_o, 0);
    chk("rel_cnt", cnt_o, 2);
    tick();
    chk("rel2_valid", valid_o, 1);
    chk("rel2_rd", rda_o, 10);
    chk("rel2_cnt", cnt_o, 2);

    // flush-only bubble is not counted
    id_clear();
    memwrite = 1; rs1a = 5'd3; rs2a = 5'd4;
    flush = 1;
    #1;
    chk("fl_noop", noop_o, 0);
    tick();
    flush = 0;
    chk("fl_memwrite", memwrite_o, 0);
    chk("fl_valid", valid_o, 0);
    chk("fl_rs1a", rs1a_o, 3);
    chk("fl_cnt", cnt_o, 2);
    chk("sat_cnt2", s_cnt, 2);

    // three more hazards: 16-bit reaches 5, 2-bit pins at 3
    for (int i = 0; i < 3; i++) begin
      id_load(5'd11, 5'd1);
      tick();
      id_add(5'd12, 5'd2, 5'd11);
      tick();
      chk("sat_bub_valid", valid_o, 0);
    end
    chk("sat_cnt16", cnt_o, 5);
    chk("sat_cnt2_max", s_cnt, 3);

    // flush together with hazard: one bubble, counted
    id_load(5'd13, 5'd1);
    tick();
    id_add(5'd14, 5'd13, 5'd2);
    flush = 1;
    tick();
    flush = 0;
    chk("fh_valid", valid_o, 0);
    chk("fh_cnt", cnt_o, 6);
    chk("fh_cnt2", s_cnt, 3);
    tick();
    chk("fh_next_valid", valid_o, 1);
    chk("fh_next_rd", rda_o, 14);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
